// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the instruction fetch controller: state encoding,
// architectural constants and small decode helpers.
package fetch_ctrl_pkg;

    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_OUT  = 2'd2,
        ST_HALT = 2'd3
    } state_e;

    localparam logic [DATA_W-1:0] NOP_INSTR   = 16'h0800;
    localparam logic [4:0]        HALT_OPCODE = 5'b00000;
    localparam logic [DATA_W-1:0] RESET_VEC   = 16'h0000;

    function automatic logic is_halt(input logic [DATA_W-1:0] instr);
        return instr[15:11] == HALT_OPCODE;
    endfunction

    // Instructions are halfword aligned, so bit 0 of any target is dropped.
    function automatic logic [DATA_W-1:0] align_pc(input logic [DATA_W-1:0] addr);
        return addr & ~16'h0001;
    endfunction

endpackage

// File: rtl/fetch_ctrl_pc_reg.sv
// Program counter register with a load mux choosing between the sequential
// successor (pc+2, wrapping) and an aligned redirect target.
module fetch_pc_reg
    import fetch_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load_en,
    input  logic        sel_redirect,
    input  logic [15:0] redirect_addr,
    output logic [15:0] pc,
    output logic [15:0] pc_plus2
);

    logic [15:0] pc_q;
    logic [15:0] pc_d;
    logic [15:0] pc_inc;

    assign pc_inc = pc_q + 16'd2;

    always_comb begin
        pc_d = pc_q;
        if (load_en) begin
            pc_d = sel_redirect ? align_pc(redirect_addr) : pc_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_VEC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc       = pc_q;
    assign pc_plus2 = pc_inc;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: issues one read at a time, hands the word to
// decode under stall back-pressure, and squashes in-flight reads on redirect.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect,
    input  logic [15:0] redirect_addr,
    input  logic        stall,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_done,
    input  logic [15:0] imem_data,
    output logic        instr_valid,
    output logic [15:0] instr_out,
    output logic [15:0] pc_plus2,
    output logic        fetch_flush
);

    state_e      state_q, state_d;
    logic        squash_q, squash_d;
    logic [15:0] ir_q, ir_d;
    logic        imem_req_q, imem_req_d;
    logic        instr_valid_q, instr_valid_d;
    logic [15:0] instr_out_q, instr_out_d;
    logic        fetch_flush_q, fetch_flush_d;

    logic        pc_load;
    logic        pc_sel_redirect;
    logic [15:0] pc;

    fetch_pc_reg u_pc (
        .clk           (clk),
        .rst           (rst),
        .load_en       (pc_load),
        .sel_redirect  (pc_sel_redirect),
        .redirect_addr (redirect_addr),
        .pc            (pc),
        .pc_plus2      (pc_plus2)
    );

    always_comb begin
        state_d         = state_q;
        squash_d        = squash_q;
        ir_d            = ir_q;
        pc_load         = 1'b0;
        pc_sel_redirect = 1'b0;
        fetch_flush_d   = redirect;

        if (redirect) begin
            pc_load         = 1'b1;
            pc_sel_redirect = 1'b1;
            unique case (state_q)
                // The request issued this cycle is now in flight; its data must be dropped.
                ST_REQ: begin
                    state_d  = ST_WAIT;
                    squash_d = 1'b1;
                end
                ST_WAIT: begin
                    if (imem_done) begin
                        state_d  = ST_REQ;
                        squash_d = 1'b0;
                    end else begin
                        squash_d = 1'b1;
                    end
                end
                default: state_d = ST_REQ;
            endcase
        end else begin
            unique case (state_q)
                ST_REQ:  state_d = ST_WAIT;
                ST_WAIT: begin
                    if (imem_done) begin
                        if (squash_q) begin
                            squash_d = 1'b0;
                            state_d  = ST_REQ;
                        end else begin
                            ir_d    = imem_data;
                            state_d = ST_OUT;
                        end
                    end
                end
                ST_OUT: begin
                    if (!stall) begin
                        pc_load = 1'b1;
                        state_d = is_halt(ir_q) ? ST_HALT : ST_REQ;
                    end
                end
                default: state_d = ST_HALT;
            endcase
        end

        // Outputs are decoded from the next state so they arrive registered.
        imem_req_d    = (state_d == ST_REQ);
        instr_valid_d = (state_d == ST_OUT);
        instr_out_d   = instr_valid_d ? ir_d : NOP_INSTR;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_REQ;
            squash_q      <= 1'b0;
            ir_q          <= NOP_INSTR;
            imem_req_q    <= 1'b1;
            instr_valid_q <= 1'b0;
            instr_out_q   <= NOP_INSTR;
            fetch_flush_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            squash_q      <= squash_d;
            ir_q          <= ir_d;
            imem_req_q    <= imem_req_d;
            instr_valid_q <= instr_valid_d;
            instr_out_q   <= instr_out_d;
            fetch_flush_q <= fetch_flush_d;
        end
    end

    assign imem_req    = imem_req_q;
    assign imem_addr   = pc;
    assign instr_valid = instr_valid_q;
    assign instr_out   = instr_out_q;
    assign fetch_flush = fetch_flush_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: a transaction-level fetch model is compared
// against the DUT every cycle, plus literal checks at key points.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect;
    logic [15:0] redirect_addr;
    logic        stall;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_done;
    logic [15:0] imem_data;
    logic        instr_valid;
    logic [15:0] instr_out;
    logic [15:0] pc_plus2;
    logic        fetch_flush;

    int checks = 0;
    int errors = 0;

    fetch_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .redirect      (redirect),
        .redirect_addr (redirect_addr),
        .stall         (stall),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_done     (imem_done),
        .imem_data     (imem_data),
        .instr_valid   (instr_valid),
        .instr_out     (instr_out),
        .pc_plus2      (pc_plus2),
        .fetch_flush   (fetch_flush)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Fetch model expressed as flags: a read to issue, a read in flight
    // (possibly doomed), an instruction held for decode, or halted.
    logic [15:0] m_pc;
    logic [15:0] m_ir;
    logic        m_issue, m_inflight, m_doomed, m_holding, m_flush;

    always @(posedge clk) begin
        if (rst) begin
            m_pc <= 16'h0000; m_ir <= 16'h0800;
            m_issue <= 1'b1; m_inflight <= 1'b0; m_doomed <= 1'b0;
            m_holding <= 1'b0; m_flush <= 1'b0;
        end else begin
            m_flush <= redirect;
            if (redirect) begin
                m_pc <= redirect_addr & 16'hFFFE;
                m_holding <= 1'b0;
                if (m_issue) begin
                    m_issue <= 1'b0; m_inflight <= 1'b1; m_doomed <= 1'b1;
                end else if (m_inflight && !imem_done) begin
                    m_doomed <= 1'b1;
                end else begin
                    m_inflight <= 1'b0; m_doomed <= 1'b0; m_issue <= 1'b1;
                end
            end else if (m_issue) begin
                m_issue <= 1'b0; m_inflight <= 1'b1;
            end else if (m_inflight) begin
                if (imem_done) begin
                    m_inflight <= 1'b0;
                    if (m_doomed) begin
                        m_doomed <= 1'b0; m_issue <= 1'b1;
                    end else begin
                        m_ir <= imem_data; m_holding <= 1'b1;
                    end
                end
            end else if (m_holding && !stall) begin
                m_pc <= m_pc + 16'd2;
                m_holding <= 1'b0;
                m_issue <= (m_ir[15:11] != 5'b00000);
            end
        end
    end

    always @(negedge clk) begin
        check("imem_req", 16'(imem_req), 16'(m_issue));
        check("instr_valid", 16'(instr_valid), 16'(m_holding));
        check("instr_out", instr_out, m_holding ? m_ir : 16'h0800);
        check("fetch_flush", 16'(fetch_flush), 16'(m_flush));
        if (m_issue) check("imem_addr", imem_addr, m_pc);
        if (m_holding) check("pc_plus2", pc_plus2, m_pc + 16'd2);
    end

    task automatic tick(input logic r, input logic [15:0] ra, input logic s,
                        input logic d, input logic [15:0] dat);
        redirect = r; redirect_addr = ra; stall = s; imem_done = d; imem_data = dat;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; redirect = 1'b0; redirect_addr = 16'h0; stall = 1'b0;
        imem_done = 1'b0; imem_data = 16'h0;
        @(negedge clk); @(negedge clk);
        check("rst_valid", 16'(instr_valid), 16'h0);
        check("rst_instr", instr_out, 16'h0800);
        check("rst_flush", 16'(fetch_flush), 16'h0);
        rst = 1'b0;
        check("first_req", 16'(imem_req), 16'h1);
        check("first_addr", imem_addr, 16'h0000);

        // Basic fetch with minimum latency
        tick(0, 0, 0, 0, 0);
        tick(0, 0, 0, 1, 16'h4001);
        check("t1_valid", 16'(instr_valid), 16'h1);
        check("t1_instr", instr_out, 16'h4001);
        check("t1_pcp2", pc_plus2, 16'h0002);
        tick(0, 0, 0, 0, 0);
        check("t1_next_addr", imem_addr, 16'h0002);

        // Stall holds the instruction
        tick(0, 0, 0, 0, 0);
        tick(0, 0, 0, 1, 16'h1234);
        for (int i = 0; i < 3; i++) begin
            tick(0, 0, 1, 0, 0);
            check("stall_instr", instr_out, 16'h1234);
            check("stall_pcp2", pc_plus2, 16'h0004);
            check("stall_req", 16'(imem_req), 16'h0);
        end
        tick(0, 0, 0, 0, 0);
        check("stall_release_addr", imem_addr, 16'h0004);

        // Redirect while waiting; late data is discarded
        tick(0, 0, 0, 0, 0);
        tick(1, 16'h0124, 0, 0, 0);
        check("wait_redir_flush", 16'(fetch_flush), 16'h1);
        tick(0, 0, 0, 0, 0);
        check("flush_one_cycle", 16'(fetch_flush), 16'h0);
        tick(0, 0, 0, 1, 16'hBEEF);
        check("beef_dropped", 16'(instr_valid), 16'h0);
        check("redir_addr", imem_addr, 16'h0124);

        // Redirect in REQ, then HALT on opcode 00000
        tick(1, 16'h0010, 0, 0, 0);
        tick(0, 0, 0, 1, 16'hAAAA);
        check("req_redir_addr", imem_addr, 16'h0010);
        tick(0, 0, 0, 0, 0);
        tick(0, 0, 0, 1, 16'h0000);
        check("halt_instr_pcp2", pc_plus2, 16'h0012);
        tick(0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            tick(0, 0, 0, 1, 16'h5555);
            check("halt_req", 16'(imem_req), 16'h0);
            check("halt_valid", 16'(instr_valid), 16'h0);
        end
        tick(1, 16'h0040, 0, 0, 0);
        check("halt_exit_addr", imem_addr, 16'h0040);
        check("halt_exit_req", 16'(imem_req), 16'h1);

        // PC wrap and odd target alignment with same-cycle done
        tick(1, 16'hFFFE, 0, 0, 0);
        tick(0, 0, 0, 1, 16'h7777);
        tick(0, 0, 0, 0, 0);
        tick(0, 0, 0, 1, 16'h2222);
        check("wrap_pcp2", pc_plus2, 16'h0000);
        tick(0, 0, 0, 0, 0);
        check("wrap_addr", imem_addr, 16'h0000);
        tick(0, 0, 0, 0, 0);
        tick(1, 16'h0031, 0, 1, 16'h3333);
        check("odd_addr", imem_addr, 16'h0030);
        check("odd_req", 16'(imem_req), 16'h1);

        // Reset while waiting
        tick(0, 0, 0, 0, 0);
        rst = 1'b1;
        tick(0, 0, 0, 0, 0);
        check("midrst_valid", 16'(instr_valid), 16'h0);
        check("midrst_flush", 16'(fetch_flush), 16'h0);
        rst = 1'b0;
        check("midrst_req", 16'(imem_req), 16'h1);
        check("midrst_addr", imem_addr, 16'h0000);
        tick(0, 0, 0, 0, 0);
        tick(0, 0, 0, 1, 16'h4001);
        check("midrst_fetch", instr_out, 16'h4001);

        // Redirect beats stall in OUT
        tick(1, 16'h0100, 1, 0, 0);
        check("out_redir_valid", 16'(instr_valid), 16'h0);
        check("out_redir_addr", imem_addr, 16'h0100);
        tick(0, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
